param_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the team's fixed 8-bit push/pop FIFO.

---
 rtl/param_sync_fifo.sv | 75 +++++++
 tb/tb_param_sync_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with occupancy, thresholds and sticky error flags
module param_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             pop_ok;
    logic             push_ok;

    // A pop frees a slot on the same edge, so a full FIFO still accepts push+pop.
    assign pop_ok  = pop & (count != '0);
    assign push_ok = push & ((count != CW'(DEPTH)) | pop_ok);

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (pop_ok) begin
                head     <= (head == LAST) ? '0 : head + 1'b1;
                data_out <= mem[head];
            end
            out_valid <= pop_ok;
            count     <= count + CW'(push_ok) - CW'(pop_ok);
            // A fresh error on the clearing edge keeps its flag set.
            overflow  <= (overflow & ~clear_err) | (push & ~push_ok);
            underflow <= (underflow & ~clear_err) | (pop & ~pop_ok);
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - scoreboard bench for param_sync_fifo (DEPTH=4 and DEPTH=5 instances)
module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic       push_a = 0, pop_a = 0, clr_a = 0;
    logic [7:0] din_a = '0, dout_a;
    logic       valid_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
    logic [2:0] cnt_a;

    logic        push_b = 0, pop_b = 0, clr_b = 0;
    logic [11:0] din_b = '0, dout_b;
    logic        valid_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
    logic [2:0]  cnt_b;

    param_sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut_a (
        .clk(clk), .reset(reset), .push(push_a), .data_in(din_a), .pop(pop_a),
        .data_out(dout_a), .out_valid(valid_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
        .overflow(ov_a), .underflow(un_a), .clear_err(clr_a)
    );

    param_sync_fifo #(.WIDTH(12), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut_b (
        .clk(clk), .reset(reset), .push(push_b), .data_in(din_b), .pop(pop_b),
        .data_out(dout_b), .out_valid(valid_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
        .overflow(ov_b), .underflow(un_b), .clear_err(clr_b)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  sb_a[$];
    int          e_cnt_a = 0;
    bit          e_valid_a = 0, e_ov_a = 0, e_un_a = 0;
    logic [11:0] sb_b[$];
    int          e_cnt_b = 0;
    bit          e_valid_b = 0, e_ov_b = 0, e_un_b = 0;

    function automatic logic [7:0] sb_pop_a();
        if (sb_a.size() == 0) return 8'hxx;
        return sb_a.pop_front();
    endfunction

    function automatic logic [11:0] sb_pop_b();
        if (sb_b.size() == 0) return 12'hxxx;
        return sb_b.pop_front();
    endfunction

    task automatic drive_a(input bit p, input logic [7:0] d, input bit q, input bit c);
        bit pok, wok;
        @(negedge clk);
        push_a = p; din_a = d; pop_a = q; clr_a = c;
        pok = q && (e_cnt_a != 0);
        wok = p && ((e_cnt_a != 4) || pok);
        if (wok) sb_a.push_back(d);
        e_cnt_a = e_cnt_a + int'(wok) - int'(pok);
        e_valid_a = pok;
        if (c) begin e_ov_a = 0; e_un_a = 0; end
        if (p && !wok) e_ov_a = 1;
        if (q && !pok) e_un_a = 1;
        @(posedge clk);
        #1;
        push_a = 0; pop_a = 0; clr_a = 0;
    endtask

    task automatic drive_b(input bit p, input logic [11:0] d, input bit q, input bit c);
        bit pok, wok;
        @(negedge clk);
        push_b = p; din_b = d; pop_b = q; clr_b = c;
        pok = q && (e_cnt_b != 0);
        wok = p && ((e_cnt_b != 5) || pok);
        if (wok) sb_b.push_back(d);
        e_cnt_b = e_cnt_b + int'(wok) - int'(pok);
        e_valid_b = pok;
        if (c) begin e_ov_b = 0; e_un_b = 0; end
        if (p && !wok) e_ov_b = 1;
        if (q && !pok) e_un_b = 1;
        @(posedge clk);
        #1;
        push_b = 0; pop_b = 0; clr_b = 0;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({cnt_a, full_a, empty_a, af_a, ae_a, valid_a, ov_a, un_a, dout_a} !== {3'd0, 7'b0101000, 8'h00}) begin
            fails++;
            $display("FAIL reset_state: got cnt=%0d f=%b e=%b af=%b ae=%b v=%b ov=%b un=%b d=%h", cnt_a, full_a, empty_a, af_a, ae_a, valid_a, ov_a, un_a, dout_a);
        end
        reset = 1'b0;
        drive_a(1, 8'd11, 0, 0);
        drive_a(1, 8'd12, 0, 0);
        drive_a(1, 8'd13, 1, 0);
        exp = sb_pop_a();
        tests++;
        if (dout_a !== exp || cnt_a !== 3'd2) begin
            fails++;
            $display("FAIL pre_reset_stream: got d=%h cnt=%0d expected d=%h cnt=2", dout_a, cnt_a, exp);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({cnt_a, full_a, empty_a, af_a, ae_a, valid_a, ov_a, un_a, dout_a} !== {3'd0, 7'b0101000, 8'h00}) begin
            fails++;
            $display("FAIL async_reset: got cnt=%0d f=%b e=%b af=%b ae=%b v=%b d=%h", cnt_a, full_a, empty_a, af_a, ae_a, valid_a, dout_a);
        end
        sb_a.delete(); e_cnt_a = 0; e_ov_a = 0; e_un_a = 0; e_valid_a = 0;
        @(negedge clk);
        reset = 1'b0;
        drive_a(0, 8'd0, 1, 0);
        tests++;
        if (un_a !== 1'b1 || valid_a !== 1'b0 || cnt_a !== 3'd0) begin
            fails++;
            $display("FAIL post_reset_pop: got un=%b v=%b cnt=%0d expected un=1 v=0 cnt=0", un_a, valid_a, cnt_a);
        end
        drive_a(0, 8'd0, 0, 1);
        tests++;
        if (un_a !== 1'b0) begin
            fails++;
            $display("FAIL clear_underflow: got %b expected 0", un_a);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive_a(1, 8'(47 + i), 0, 0);
            tests++;
            if (cnt_a !== 3'(i + 1) || af_a !== (i + 1 >= 3) || full_a !== (i == 3) || empty_a !== 1'b0) begin
                fails++;
                $display("FAIL fill_%0d: got cnt=%0d af=%b full=%b empty=%b", i, cnt_a, af_a, full_a, empty_a);
            end
        end
        drive_a(1, 8'd51, 0, 0);
        tests++;
        if (ov_a !== 1'b1 || cnt_a !== 3'd4) begin
            fails++;
            $display("FAIL overflow_push: got ov=%b cnt=%0d expected ov=1 cnt=4", ov_a, cnt_a);
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(0, 8'd0, 1, 0);
            exp = sb_pop_a();
            tests++;
            if (valid_a !== 1'b1 || dout_a !== exp || dout_a !== 8'(47 + i)) begin
                fails++;
                $display("FAIL drain_%0d: got v=%b d=%0d expected v=1 d=%0d", i, valid_a, dout_a, 47 + i);
            end
        end
        tests++;
        if (empty_a !== 1'b1 || cnt_a !== 3'd0 || ae_a !== 1'b1) begin
            fails++;
            $display("FAIL drained_empty: got empty=%b cnt=%0d ae=%b", empty_a, cnt_a, ae_a);
        end
    endtask

    task automatic test_sticky();
        logic [7:0] exp;
        drive_a(0, 8'd0, 0, 1);
        tests++;
        if (ov_a !== 1'b0) begin fails++; $display("FAIL clear_overflow: got %b expected 0", ov_a); end
        for (int i = 0; i < 4; i++) drive_a(1, 8'(8'h10 + i), 0, 0);
        drive_a(1, 8'hEE, 0, 1);
        tests++;
        if (ov_a !== 1'b1 || cnt_a !== 3'd4) begin
            fails++;
            $display("FAIL clear_vs_new_overflow: got ov=%b cnt=%0d expected ov=1 cnt=4", ov_a, cnt_a);
        end
        drive_a(0, 8'd0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive_a(0, 8'd0, 1, 0);
            exp = sb_pop_a();
            tests++;
            if (dout_a !== exp || valid_a !== 1'b1) begin
                fails++;
                $display("FAIL sticky_drain_%0d: got d=%h v=%b expected d=%h", i, dout_a, valid_a, exp);
            end
        end
        drive_a(0, 8'd0, 1, 1);
        tests++;
        if (un_a !== 1'b1 || ov_a !== 1'b0) begin
            fails++;
            $display("FAIL clear_vs_new_underflow: got un=%b ov=%b expected un=1 ov=0", un_a, ov_a);
        end
        drive_a(0, 8'd0, 0, 1);
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) drive_a(1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_a(0, 8'd0, 1, 0);
            exp = sb_pop_a();
            tests++;
            if (dout_a !== exp) begin fails++; $display("FAIL wrap_pre_%0d: got %h expected %h", i, dout_a, exp); end
        end
        for (int i = 0; i < 4; i++) drive_a(1, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive_a(0, 8'd0, 1, 0);
            exp = sb_pop_a();
            tests++;
            if (dout_a !== exp || dout_a !== 8'(8'hA0 + i) || valid_a !== 1'b1) begin
                fails++;
                $display("FAIL wrap_%0d: got d=%h v=%b expected d=%h", i, dout_a, valid_a, 8'hA0 + i);
            end
        end
        tests++;
        if (ov_a !== 1'b0 || un_a !== 1'b0 || empty_a !== 1'b1) begin
            fails++;
            $display("FAIL wrap_flags: got ov=%b un=%b empty=%b expected 0 0 1", ov_a, un_a, empty_a);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) drive_a(1, 8'(8'h60 + i), 0, 0);
        drive_a(1, 8'h55, 1, 0);
        exp = sb_pop_a();
        tests++;
        if (cnt_a !== 3'd4 || full_a !== 1'b1 || valid_a !== 1'b1 || dout_a !== exp || dout_a !== 8'h60 || ov_a !== 1'b0) begin
            fails++;
            $display("FAIL full_push_pop: got cnt=%0d full=%b v=%b d=%h ov=%b expected 4 1 1 60 0", cnt_a, full_a, valid_a, dout_a, ov_a);
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(0, 8'd0, 1, 0);
            exp = sb_pop_a();
            tests++;
            if (dout_a !== exp || (i == 3 && dout_a !== 8'h55)) begin
                fails++;
                $display("FAIL full_pp_drain_%0d: got %h expected %h", i, dout_a, exp);
            end
        end
        drive_a(1, 8'h66, 1, 0);
        tests++;
        if (cnt_a !== 3'd1 || un_a !== 1'b1 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL empty_push_pop: got cnt=%0d un=%b v=%b expected 1 1 0", cnt_a, un_a, valid_a);
        end
        drive_a(0, 8'd0, 1, 1);
        exp = sb_pop_a();
        tests++;
        if (dout_a !== exp || dout_a !== 8'h66 || un_a !== 1'b0 || cnt_a !== 3'd0) begin
            fails++;
            $display("FAIL empty_pp_follow: got d=%h un=%b cnt=%0d expected 66 0 0", dout_a, un_a, cnt_a);
        end
    endtask

    task automatic test_nonpow2();
        bit p, q, c;
        logic [11:0] exp;
        for (int i = 0; i < 30; i++) begin
            p = (i < 15) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            q = (i < 15) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) == 0);
            drive_b(p, 12'($urandom), q, c);
            tests++;
            if ({cnt_b, full_b, empty_b, af_b, ae_b, ov_b, un_b, valid_b} !==
                {3'(e_cnt_b), e_cnt_b == 5, e_cnt_b == 0, e_cnt_b >= 4, e_cnt_b <= 1, e_ov_b, e_un_b, e_valid_b}) begin
                fails++;
                $display("FAIL np2_cycle_%0d: got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b v=%b expected cnt=%0d ov=%b un=%b v=%b",
                         i, cnt_b, full_b, empty_b, af_b, ae_b, ov_b, un_b, valid_b, e_cnt_b, e_ov_b, e_un_b, e_valid_b);
            end
            if (valid_b === 1'b1) begin
                exp = sb_pop_b();
                tests++;
                if (dout_b !== exp) begin
                    fails++;
                    $display("FAIL np2_data_%0d: got %h expected %h", i, dout_b, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_sticky();
        test_wrap();
        test_simultaneous();
        test_nonpow2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
